// File: rtl/hex_display_scheduler_if.sv
// Bus between board logic, the shared hex decoder and the scheduler.
// master = board/decoder side, slave = scheduler.
interface hex_display_scheduler_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] value;
    logic [NUM_DIGITS-1:0]   blank_mask;
    logic                    load;
    logic                    busy;
    logic [3:0]              dec_nibble;
    logic [6:0]              dec_seg;
    logic [7*NUM_DIGITS-1:0] HEX_ALL;
    logic                    frame_done;

    modport master (
        output value, blank_mask, load, dec_seg,
        input  busy, dec_nibble, HEX_ALL, frame_done
    );

    modport slave (
        input  value, blank_mask, load, dec_seg,
        output busy, dec_nibble, HEX_ALL, frame_done
    );
endinterface

// File: rtl/hex_display_scheduler.sv
// Time-shares one hex_7seg decoder across NUM_DIGITS display digits.
// Optional LEADING_ZERO_BLANK_EN: blank leading zero digits at load.
module hex_display_scheduler #(
    parameter int NUM_DIGITS = 8,
    parameter int SCAN_DIV   = 1024
) (
    input logic                    CLOCK_50,
    input logic                    RESET_N,
    hex_display_scheduler_if.slave bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int VAL_W = 4 * NUM_DIGITS;
    localparam int SEG_W = 7 * NUM_DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        SEL,
        CAPT,
        HOLD
    } state_t;

    state_t state;
    state_t state_nx;

    logic [VAL_W-1:0]      shadow_val;
    logic [NUM_DIGITS-1:0] shadow_blank;
    logic [NUM_DIGITS-1:0] blank_eff;
    logic [IDX_W-1:0]      idx;
    logic [CNT_W-1:0]      cnt;
    logic [SEG_W-1:0]      seg_all;
    logic [3:0]            nibble;
    logic                  busy;
    logic                  done;

    logic last_digit;
    logic cnt_zero;
    logic do_load;
    logic do_sel;
    logic do_capt;
    logic do_hold;

    assign last_digit = (idx == IDX_W'(NUM_DIGITS - 1));
    assign cnt_zero   = (cnt == '0);

`ifdef LEADING_ZERO_BLANK_EN
    logic [NUM_DIGITS-1:0] lz;

    // Mark digits above 0 whose nibble and all higher nibbles are zero
    always_comb begin
        logic zero_run;
        zero_run = 1'b1;
        lz       = '0;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run & (bus.value[4*i +: 4] == 4'h0);
            lz[i]    = zero_run;
        end
        blank_eff = bus.blank_mask | lz;
    end
`else
    assign blank_eff = bus.blank_mask;
`endif

    // State register
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nx;
    end

    // Next-state logic: SEL and CAPT take one cycle each, HOLD paces the scan
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (bus.load) state_nx = SEL;
            SEL:  state_nx = CAPT;
            CAPT: state_nx = last_digit ? IDLE : HOLD;
            HOLD: if (cnt_zero) state_nx = SEL;
            default: state_nx = IDLE;
        endcase
    end

    // Per-state datapath strobes
    always_comb begin
        do_load = (state == IDLE) && bus.load;
        do_sel  = (state == SEL);
        do_capt = (state == CAPT);
        do_hold = (state == HOLD);
    end

    // Registered datapath: shadow capture, decoder feed, segment capture
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            shadow_val   <= '0;
            shadow_blank <= '0;
            idx          <= '0;
            cnt          <= '0;
            nibble       <= 4'h0;
            busy         <= 1'b0;
            done         <= 1'b0;
            seg_all      <= {NUM_DIGITS{7'h7F}};
        end else begin
            done <= do_capt && last_digit;
            if (do_load) begin
                shadow_val   <= bus.value;
                shadow_blank <= blank_eff;
                idx          <= '0;
                busy         <= 1'b1;
            end
            if (do_sel) nibble <= shadow_val[{idx, 2'b00} +: 4];
            if (do_capt) begin
                if (last_digit) busy <= 1'b0;
                else            cnt  <= CNT_W'(SCAN_DIV - 1);
            end
            if (do_hold) begin
                if (cnt_zero) idx <= idx + 1'b1;
                else          cnt <= cnt - 1'b1;
            end
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (do_capt && idx == IDX_W'(i))
                    seg_all[7*i +: 7] <= shadow_blank[i] ? 7'h7F : bus.dec_seg;
            end
        end
    end

    assign bus.dec_nibble = nibble;
    assign bus.busy       = busy;
    assign bus.frame_done = done;
    assign bus.HEX_ALL    = seg_all;
endmodule

// File: tb/tb_hex_display_scheduler.sv
// Scoreboard bench for hex_display_scheduler (NUM_DIGITS=8, SCAN_DIV=2).
// Expected segment words are hand-computed per directed vector.
module tb_hex_display_scheduler;
    localparam int ND        = 8;
    localparam int SD        = 2;
    localparam int FRAME_CYC = 30;

    localparam logic [55:0] HEX_A = {~7'h07, ~7'h7D, ~7'h6D, ~7'h66,
                                     ~7'h4F, ~7'h5B, ~7'h06, ~7'h3F};
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [55:0] HEX_B = {{6{7'h7F}}, 7'h7F, ~7'h6D};
    localparam logic [55:0] HEX_D = {7'h7F, ~7'h06, ~7'h5B, ~7'h4F,
                                     ~7'h66, ~7'h6D, ~7'h7D, ~7'h07};
`else
    localparam logic [55:0] HEX_B = {{6{~7'h3F}}, 7'h7F, ~7'h6D};
    localparam logic [55:0] HEX_D = {~7'h3F, ~7'h06, ~7'h5B, ~7'h4F,
                                     ~7'h66, ~7'h6D, ~7'h7D, ~7'h07};
`endif
    localparam logic [55:0] HEX_C = {~7'h7F, ~7'h6F, ~7'h77, ~7'h7C,
                                     ~7'h39, ~7'h5E, ~7'h79, ~7'h71};
    localparam logic [55:0] HEX_OFF = {8{7'h7F}};

    typedef struct {
        logic [31:0] val;
        logic [55:0] hex;
    } item_t;

    logic  CLOCK_50 = 1'b0;
    logic  RESET_N  = 1'b0;
    item_t sb[$];
    int    checks = 0;
    int    errors = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    hex_display_scheduler_if #(.NUM_DIGITS(ND)) bus ();

    hex_display_scheduler #(
        .NUM_DIGITS(ND),
        .SCAN_DIV  (SD)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .RESET_N (RESET_N),
        .bus     (bus.slave)
    );

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;
            4'h1: return 7'h06;
            4'h2: return 7'h5B;
            4'h3: return 7'h4F;
            4'h4: return 7'h66;
            4'h5: return 7'h6D;
            4'h6: return 7'h7D;
            4'h7: return 7'h07;
            4'h8: return 7'h7F;
            4'h9: return 7'h6F;
            4'hA: return 7'h77;
            4'hB: return 7'h7C;
            4'hC: return 7'h39;
            4'hD: return 7'h5E;
            4'hE: return 7'h79;
            default: return 7'h71;
        endcase
    endfunction

    assign bus.dec_seg = ~seg7(bus.dec_nibble);

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: scan order during a frame, result and length at frame_done
    initial begin
        int    k;
        item_t it;
        logic [31:0] v;
        k = 0;
        forever begin
            @(negedge CLOCK_50);
            if (!RESET_N) begin
                k = 0;
            end else if (bus.frame_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_frame_done: got 1 expected 0");
                end else begin
                    it = sb.pop_front();
                    check("hex_all", 64'(bus.HEX_ALL), 64'(it.hex));
                    check("frame_len", 64'(k), 64'(FRAME_CYC));
                    check("busy_at_done", 64'(bus.busy), 64'd0);
                end
                k = 0;
            end else if (bus.busy) begin
                k++;
                if (k >= 2 && sb.size() > 0) begin
                    v = sb[0].val;
                    check("scan_nibble", 64'(bus.dec_nibble),
                          64'(v[4*((k-2)/4) +: 4]));
                end
            end
        end
    end

    task automatic start_frame(input logic [31:0] val, input logic [7:0] mask,
                               input logic [55:0] hex);
        item_t it;
        @(negedge CLOCK_50);
        bus.value      = val;
        bus.blank_mask = mask;
        bus.load       = 1'b1;
        it.val = val;
        it.hex = hex;
        sb.push_back(it);
        @(negedge CLOCK_50);
        bus.load = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 200; i++) begin
            @(negedge CLOCK_50);
            if (bus.frame_done) return;
        end
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no frame_done expected one", name);
    endtask

    initial begin
        item_t it;
        bus.value      = '0;
        bus.blank_mask = '0;
        bus.load       = 1'b0;
        #35;
        check("rst_hex", 64'(bus.HEX_ALL), 64'(HEX_OFF));
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.frame_done), 64'd0);
        check("rst_nibble", 64'(bus.dec_nibble), 64'd0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;

        start_frame(32'h76543210, 8'h00, HEX_A);
        wait_done("basic");

        start_frame(32'h000000A5, 8'h02, HEX_B);
        wait_done("blank");

        start_frame(32'h89ABCDEF, 8'h00, HEX_C);
        repeat (4) @(negedge CLOCK_50);
        bus.value      = 32'hFFFFFFFF;
        bus.blank_mask = 8'hFF;
        bus.load       = 1'b1;
        @(negedge CLOCK_50);
        bus.load = 1'b0;
        wait_done("reject");
        repeat (40) @(negedge CLOCK_50);
        check("reject_hold", 64'(bus.HEX_ALL), 64'(HEX_C));

        @(negedge CLOCK_50);
        bus.value      = 32'h76543210;
        bus.blank_mask = 8'h00;
        bus.load       = 1'b1;
        it.val = 32'h76543210;
        it.hex = HEX_A;
        sb.push_back(it);
        wait_done("b2b_first");
        check("b2b_idle_at_done", 64'(bus.busy), 64'd0);
        bus.value = 32'h01234567;
        it.val = 32'h01234567;
        it.hex = HEX_D;
        sb.push_back(it);
        @(negedge CLOCK_50);
        check("b2b_restart", 64'(bus.busy), 64'd1);
        bus.load = 1'b0;
        wait_done("b2b_second");

        start_frame(32'h76543210, 8'h00, HEX_A);
        repeat (6) @(negedge CLOCK_50);
        #3;
        RESET_N = 1'b0;
        sb.delete();
        #1;
        check("midrst_hex", 64'(bus.HEX_ALL), 64'(HEX_OFF));
        check("midrst_busy", 64'(bus.busy), 64'd0);
        @(negedge CLOCK_50);
        RESET_N = 1'b1;
        repeat (40) @(negedge CLOCK_50);
        check("postrst_hex", 64'(bus.HEX_ALL), 64'(HEX_OFF));
        check("postrst_busy", 64'(bus.busy), 64'd0);

        check("queue_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end
endmodule
